// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: shared constants and types for the PS/2 scancode-set-2 key tracker.
//   - Protocol bytes (extended prefix, break prefix, BAT-complete).
//   - Keyboard response bytes that never form part of a scancode.
//   - FSM state encoding.
//   - Default {extended, code} values for the keys the game uses.
package ps2_kbd_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_BAT    = 8'hAA;

  // Host-command responses and error bytes: consumed silently in IDLE
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR_LO = 8'h00;
  localparam logic [7:0] PS2_ERR_HI = 8'hFF;

  localparam logic [8:0] KC_ENTER   = 9'h05A;
  localparam logic [8:0] KC_LEFT    = 9'h16B;
  localparam logic [8:0] KC_RIGHT   = 9'h174;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0
  } ps2_state_t;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == PS2_ACK)    || (b == PS2_ECHO)   || (b == PS2_RESEND) ||
           (b == PS2_ERR_LO) || (b == PS2_ERR_HI);
  endfunction

endpackage

// File: rtl/ps2_key_match.sv
// ps2_key_match: combinational compare of one {extended, code} value against
// a packed table of NUM_KEYS entries.
//   code  in   9         {extended, scancode} under test
//   hit   out  NUM_KEYS  bit i set when table slice i equals code; several bits
//                        may be set when the table holds duplicates
module ps2_key_match
  import ps2_kbd_pkg::*;
#(
  parameter int                      NUM_KEYS  = 3,
  parameter logic [NUM_KEYS*9-1:0]   KEY_CODES = {KC_RIGHT, KC_LEFT, KC_ENTER}
) (
  input  logic [8:0]          code,
  output logic [NUM_KEYS-1:0] hit
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      hit[i] = (KEY_CODES[i*9 +: 9] == code);
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: turns the PS2_Controller byte stream into per-key state.
//   CLOCK_50       in   1         system clock
//   resetn         in   1         asynchronous active-low reset
//   rx_data        in   8         received byte
//   rx_valid       in   1         one-cycle strobe qualifying rx_data
//   clear          in   1         synchronous soft clear (wins over rx_valid)
//   key_held       out  NUM_KEYS  level per tracked key
//   key_press      out  NUM_KEYS  one-cycle pulse on up->down
//   key_release    out  NUM_KEYS  one-cycle pulse on down->up
//   last_code      out  9         {extended, code} of the latest make/break
//   last_is_break  out  1         latest event was a break
//   event_valid    out  1         one-cycle pulse per completed make/break
//   proto_error    out  1         one-cycle pulse on bad sequence or prefix timeout
//
// state        | meaning
// -------------+-----------------------------------------------
// ST_IDLE      | between scancodes, next byte starts a sequence
// ST_GOT_E0    | extended prefix seen
// ST_GOT_F0    | break prefix seen
// ST_GOT_E0F0  | extended break prefix seen
module ps2_key_tracker
  import ps2_kbd_pkg::*;
#(
  parameter int                      NUM_KEYS       = 3,
  parameter logic [NUM_KEYS*9-1:0]   KEY_CODES      = {KC_RIGHT, KC_LEFT, KC_ENTER},
  parameter int                      TIMEOUT_CYCLES = 100000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic                clear,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [8:0]          last_code,
  output logic                last_is_break,
  output logic                event_valid,
  output logic                proto_error
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t          state;
  logic [CNT_W-1:0]    to_cnt;
  logic [8:0]          evt_code;
  logic [NUM_KEYS-1:0] hit;

  // The extended bit comes from the prefix already seen, so the table lookup
  // can run on the byte as it arrives.
  assign evt_code = {(state == ST_GOT_E0) || (state == ST_GOT_E0F0), rx_data};

  ps2_key_match #(
    .NUM_KEYS  (NUM_KEYS),
    .KEY_CODES (KEY_CODES)
  ) u_match (
    .code (evt_code),
    .hit  (hit)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      to_cnt        <= '0;
      key_held      <= '0;
      key_press     <= '0;
      key_release   <= '0;
      last_code     <= '0;
      last_is_break <= 1'b0;
      event_valid   <= 1'b0;
      proto_error   <= 1'b0;
    end else begin
      key_press   <= '0;
      key_release <= '0;
      event_valid <= 1'b0;
      proto_error <= 1'b0;

      if (clear) begin
        state         <= ST_IDLE;
        to_cnt        <= '0;
        key_held      <= '0;
        last_code     <= '0;
        last_is_break <= 1'b0;
      end else if (rx_valid) begin
        to_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (rx_data == PS2_EXT) begin
              state <= ST_GOT_E0;
            end else if (rx_data == PS2_BRK) begin
              state <= ST_GOT_F0;
            end else if (rx_data == PS2_BAT) begin
              // Keyboard self-test: everything it reported down is now up
              key_release <= key_held;
              key_held    <= '0;
            end else if (!is_ignored(rx_data)) begin
              key_press     <= hit & ~key_held;
              key_held      <= key_held | hit;
              last_code     <= evt_code;
              last_is_break <= 1'b0;
              event_valid   <= 1'b1;
            end
          end
          ST_GOT_E0: begin
            if (rx_data == PS2_BRK) begin
              state <= ST_GOT_E0F0;
            end else if (rx_data != PS2_EXT) begin
              key_press     <= hit & ~key_held;
              key_held      <= key_held | hit;
              last_code     <= evt_code;
              last_is_break <= 1'b0;
              event_valid   <= 1'b1;
              state         <= ST_IDLE;
            end
          end
          ST_GOT_F0, ST_GOT_E0F0: begin
            if ((rx_data == PS2_EXT) || (rx_data == PS2_BRK)) begin
              proto_error <= 1'b1;
            end else begin
              key_release   <= hit & key_held;
              key_held      <= key_held & ~hit;
              last_code     <= evt_code;
              last_is_break <= 1'b1;
              event_valid   <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        // A prefix with no follow-up byte: abandon it, keep key state
        if (to_cnt == TO_LAST) begin
          state       <= ST_IDLE;
          to_cnt      <= '0;
          proto_error <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;

  localparam int NK = 3;
  localparam int TO = 40;

  logic          CLOCK_50 = 1'b0;
  logic          resetn;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          clear;
  logic [NK-1:0] key_held;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [8:0]    last_code;
  logic          last_is_break;
  logic          event_valid;
  logic          proto_error;

  int vectors = 0;
  int errs    = 0;

  ps2_key_tracker #(
    .NUM_KEYS       (NK),
    .KEY_CODES      ({9'h174, 9'h16B, 9'h05A}),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .resetn        (resetn),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .clear         (clear),
    .key_held      (key_held),
    .key_press     (key_press),
    .key_release   (key_release),
    .last_code     (last_code),
    .last_is_break (last_is_break),
    .event_valid   (event_valid),
    .proto_error   (proto_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns on the falling edge after the sampling edge, so the byte's
  // registered effect (including pulses) is visible.
  task automatic send(input logic [7:0] b);
    @(negedge CLOCK_50);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] held, input logic [2:0] prs,
                         input logic [2:0] rel, input logic [8:0] code, input logic brk,
                         input logic ev, input logic err);
    chk({tag, ".held"},  16'(key_held),      16'(held));
    chk({tag, ".press"}, 16'(key_press),     16'(prs));
    chk({tag, ".rel"},   16'(key_release),   16'(rel));
    chk({tag, ".code"},  16'(last_code),     16'(code));
    chk({tag, ".brk"},   16'(last_is_break), 16'(brk));
    chk({tag, ".ev"},    16'(event_valid),   16'(ev));
    chk({tag, ".err"},   16'(proto_error),   16'(err));
  endtask

  initial begin
    resetn = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; clear = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk_all("reset", 3'b000, 3'b000, 3'b000, 9'h000, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    @(negedge CLOCK_50);

    // Enter make then break
    send(8'h5A); chk_all("ent_mk", 3'b001, 3'b001, 3'b000, 9'h05A, 1'b0, 1'b1, 1'b0);
    send(8'hF0); chk_all("ent_f0", 3'b001, 3'b000, 3'b000, 9'h05A, 1'b0, 1'b0, 1'b0);
    send(8'h5A); chk_all("ent_bk", 3'b000, 3'b000, 3'b001, 9'h05A, 1'b1, 1'b1, 1'b0);
    @(negedge CLOCK_50);
    chk_all("ent_idle", 3'b000, 3'b000, 3'b000, 9'h05A, 1'b1, 1'b0, 1'b0);

    // Left with typematic repeats
    send(8'hE0); chk_all("lft_e0", 3'b000, 3'b000, 3'b000, 9'h05A, 1'b1, 1'b0, 1'b0);
    send(8'h6B); chk_all("lft_mk1", 3'b010, 3'b010, 3'b000, 9'h16B, 1'b0, 1'b1, 1'b0);
    send(8'hE0); send(8'h6B);
    chk_all("lft_mk2", 3'b010, 3'b000, 3'b000, 9'h16B, 1'b0, 1'b1, 1'b0);
    send(8'hE0); send(8'h6B);
    chk_all("lft_mk3", 3'b010, 3'b000, 3'b000, 9'h16B, 1'b0, 1'b1, 1'b0);
    send(8'hE0); send(8'hF0);
    chk_all("lft_e0f0", 3'b010, 3'b000, 3'b000, 9'h16B, 1'b0, 1'b0, 1'b0);
    send(8'h6B); chk_all("lft_bk", 3'b000, 3'b000, 3'b010, 9'h16B, 1'b1, 1'b1, 1'b0);

    // Left and Right together, release Left only
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h74);
    chk_all("rgt_mk", 3'b110, 3'b100, 3'b000, 9'h174, 1'b0, 1'b1, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h6B);
    chk_all("lr_rel_l", 3'b100, 3'b000, 3'b010, 9'h16B, 1'b1, 1'b1, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h74);
    chk_all("lr_rel_r", 3'b000, 3'b000, 3'b100, 9'h174, 1'b1, 1'b1, 1'b0);

    // Unmatched code, then a malformed break prefix
    send(8'h6B); chk_all("bare6b", 3'b000, 3'b000, 3'b000, 9'h06B, 1'b0, 1'b1, 1'b0);
    send(8'hFA); chk_all("ack_ign", 3'b000, 3'b000, 3'b000, 9'h06B, 1'b0, 1'b0, 1'b0);
    send(8'hF0); send(8'hE0);
    chk_all("f0e0_err", 3'b000, 3'b000, 3'b000, 9'h06B, 1'b0, 1'b0, 1'b1);
    send(8'h5A); chk_all("after_err", 3'b001, 3'b001, 3'b000, 9'h05A, 1'b0, 1'b1, 1'b0);
    send(8'hF0); send(8'h5A);
    chk_all("after_err_bk", 3'b000, 3'b000, 3'b001, 9'h05A, 1'b1, 1'b1, 1'b0);

    // Prefix timeout: error exactly TO cycles after the E0 was sampled
    send(8'hE0);
    for (int i = 1; i < TO; i++) begin
      @(negedge CLOCK_50);
      chk("to_wait", 16'(proto_error), 16'd0);
    end
    @(negedge CLOCK_50);
    chk_all("to_fire", 3'b000, 3'b000, 3'b000, 9'h05A, 1'b1, 1'b0, 1'b1);
    @(negedge CLOCK_50);
    chk("to_pulse_w", 16'(proto_error), 16'd0);
    send(8'h5A); chk_all("to_next", 3'b001, 3'b001, 3'b000, 9'h05A, 1'b0, 1'b1, 1'b0);

    // Byte arriving on the timeout cycle is decoded, no error
    send(8'hE0);
    repeat (TO - 2) @(negedge CLOCK_50);
    chk("coin_pre", 16'(proto_error), 16'd0);
    send(8'h6B); chk_all("coin", 3'b011, 3'b010, 3'b000, 9'h16B, 1'b0, 1'b1, 1'b0);
    @(negedge CLOCK_50);
    chk("coin_post", 16'(proto_error), 16'd0);

    // BAT releases everything held
    send(8'hAA); chk_all("bat", 3'b000, 3'b000, 3'b011, 9'h16B, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-prefix
    send(8'h5A);
    send(8'hE0);
    #3 resetn = 1'b0;
    #1 chk_all("arst", 3'b000, 3'b000, 3'b000, 9'h000, 1'b0, 1'b0, 1'b0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    send(8'hF0); send(8'h5A);
    chk_all("arst_next", 3'b000, 3'b000, 3'b000, 9'h05A, 1'b1, 1'b1, 1'b0);

    // Synchronous clear overrides a simultaneous byte
    send(8'h5A);
    send(8'hE0);
    @(negedge CLOCK_50);
    clear = 1'b1; rx_data = 8'h6B; rx_valid = 1'b1;
    @(negedge CLOCK_50);
    clear = 1'b0; rx_valid = 1'b0;
    chk_all("clear", 3'b000, 3'b000, 3'b000, 9'h000, 1'b0, 1'b0, 1'b0);
    send(8'hF0); send(8'h5A);
    chk_all("clear_next", 3'b000, 3'b000, 3'b000, 9'h05A, 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
